alu_operand_fetch: RTL and testbench

- Operand-side counterpart of the ALU result register in the multicycle datapath.
- Sequences register-file reads through the single synchronous read port and captures operand A and operand B (or the immediate).
- Presents the operand pair to the ALU with a valid/ready handshake, so ALU result capture happens only on accepted operands.
- Sits between the control unit's issue strobe and the ALU inputs.

---
 rtl/alu_operand_fetch_if.sv | 28 ++
 rtl/alu_operand_fetch.sv | 62 ++++++
 tb/tb_alu_operand_fetch.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/alu_operand_fetch_if.sv
// alu_operand_fetch_if: issue, register-file read port and ALU operand handshake bundle
interface alu_operand_fetch_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic              start;
  logic [ADDR_W-1:0] src_a;
  logic [ADDR_W-1:0] src_b;
  logic              use_imm;
  logic [DATA_W-1:0] imm;
  logic              flush;
  logic              rf_rd_en;
  logic [ADDR_W-1:0] rf_rd_addr;
  logic [DATA_W-1:0] rf_rd_data;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              op_valid;
  logic              op_ready;
  logic              busy;
  modport master (
    output start, src_a, src_b, use_imm, imm, flush, rf_rd_data, op_ready,
    input  rf_rd_en, rf_rd_addr, op_a, op_b, op_valid, busy
  );
  modport slave (
    input  start, src_a, src_b, use_imm, imm, flush, rf_rd_data, op_ready,
    output rf_rd_en, rf_rd_addr, op_a, op_b, op_valid, busy
  );
endinterface

// File: rtl/alu_operand_fetch.sv
// alu_operand_fetch: sequences RF reads for operands A/B (or immediate) and hands them to the ALU
module alu_operand_fetch #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 3,
  parameter bit R0_ZERO = 1'b1
) (
  input logic                clk,
  input logic                rst,
  alu_operand_fetch_if.slave fetch_if
);
  typedef enum logic [2:0] {IDLE, RD_A, RD_B, CAP_B, VALID} state_e;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] a_addr_q, b_addr_q;
  logic [DATA_W-1:0] imm_q, op_a_q, op_b_q, rd_a, rd_b;
  logic              use_imm_q, load;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = fetch_if.start ? RD_A : IDLE;
      RD_A:    state_d = RD_B;
      RD_B:    state_d = use_imm_q ? VALID : CAP_B;
      CAP_B:   state_d = VALID;
      VALID:   state_d = fetch_if.op_ready ? (fetch_if.start ? RD_A : IDLE) : VALID;
      default: state_d = IDLE;
    endcase
    if (fetch_if.flush) state_d = IDLE;
  end
  // RD_A is only ever entered from an accepted issue, so it doubles as the request latch strobe
  assign load = state_d == RD_A;
  assign rd_a = (R0_ZERO && a_addr_q == '0) ? '0 : fetch_if.rf_rd_data;
  assign rd_b = (R0_ZERO && b_addr_q == '0) ? '0 : fetch_if.rf_rd_data;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_addr_q  <= '0;
      b_addr_q  <= '0;
      imm_q     <= '0;
      use_imm_q <= 1'b0;
      op_a_q    <= '0;
      op_b_q    <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        a_addr_q  <= fetch_if.src_a;
        b_addr_q  <= fetch_if.src_b;
        imm_q     <= fetch_if.imm;
        use_imm_q <= fetch_if.use_imm;
      end
      if (!fetch_if.flush && state_q == RD_B) begin
        op_a_q <= rd_a;
        if (use_imm_q) op_b_q <= imm_q;
      end
      if (!fetch_if.flush && state_q == CAP_B) op_b_q <= rd_b;
    end
  end
  assign fetch_if.rf_rd_en   = state_q == RD_A || (state_q == RD_B && !use_imm_q);
  assign fetch_if.rf_rd_addr = state_q == RD_A ? a_addr_q : state_q == RD_B ? b_addr_q : '0;
  assign fetch_if.op_a       = op_a_q;
  assign fetch_if.op_b       = op_b_q;
  assign fetch_if.op_valid   = state_q == VALID;
  assign fetch_if.busy       = state_q != IDLE;
endmodule

// File: tb/tb_alu_operand_fetch.sv
// tb_alu_operand_fetch: scoreboard bench with a registered RF model behind the read port
module tb_alu_operand_fetch;
  logic clk, rst;
  int n_chk, n_pass;
  logic force_ff;
  logic [15:0] rf [8];
  logic [15:0] rf_q;
  logic [31:0] sb [$];
  alu_operand_fetch_if #(.DATA_W(16), .ADDR_W(3)) bus ();
  alu_operand_fetch #(.DATA_W(16), .ADDR_W(3), .R0_ZERO(1'b1)) dut (.clk(clk), .rst(rst), .fetch_if(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.rf_rd_en) rf_q <= rf[bus.rf_rd_addr];
  assign bus.rf_rd_data = force_ff ? 16'hFFFF : rf_q;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [2:0] a, input logic [2:0] b, input logic ui, input logic [15:0] im, input logic [31:0] exp);
    bus.start   = 1'b1;
    bus.src_a   = a;
    bus.src_b   = b;
    bus.use_imm = ui;
    bus.imm     = im;
    sb.push_back(exp);
  endtask
  always @(negedge clk) begin
    if (!rst && bus.op_valid && bus.op_ready) begin
      if (sb.size() == 0) check("sb_empty", 32'd1, 32'd0);
      else begin
        logic [31:0] e;
        e = sb.pop_front();
        check("op_a", {16'd0, bus.op_a}, {16'd0, e[31:16]});
        check("op_b", {16'd0, bus.op_b}, {16'd0, e[15:0]});
      end
    end
  end
  initial begin
    rst = 1'b1; force_ff = 1'b0; rf_q = '0;
    for (int i = 0; i < 8; i++) rf[i] = 16'h0;
    rf[1] = 16'h8001; rf[2] = 16'h1234; rf[3] = 16'hAAAA; rf[4] = 16'h4444; rf[5] = 16'h00FF; rf[6] = 16'h6666;
    bus.start = 0; bus.src_a = 0; bus.src_b = 0; bus.use_imm = 0; bus.imm = 0; bus.flush = 0; bus.op_ready = 0;
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle", {bus.rf_rd_en, bus.op_valid, bus.busy, bus.rf_rd_addr, bus.op_a, bus.op_b}, 32'd0);
    end
    // register-register fetch; inputs scrambled after acceptance
    bus.op_ready = 1'b1;
    issue(3'd2, 3'd5, 1'b0, 16'h0, {16'h1234, 16'h00FF});
    step();
    bus.start = 0; bus.src_a = 3'd7; bus.src_b = 3'd7; bus.use_imm = 1'b1;
    check("rr_rda", {bus.rf_rd_en, bus.busy, bus.rf_rd_addr}, {1'b1, 1'b1, 3'd2});
    step();
    check("rr_rdb", {bus.rf_rd_en, bus.busy, bus.rf_rd_addr}, {1'b1, 1'b1, 3'd5});
    step();
    check("rr_capb", {bus.rf_rd_en, bus.op_valid, bus.busy, bus.rf_rd_addr}, {1'b0, 1'b0, 1'b1, 3'd0});
    step();
    check("rr_valid", {bus.op_valid, bus.busy}, 2'b11);
    step();
    check("rr_done", {bus.op_valid, bus.busy}, 2'b00);
    // immediate fetch: one RF read only
    issue(3'd3, 3'd6, 1'b1, 16'h0F0F, {16'hAAAA, 16'h0F0F});
    step();
    bus.start = 0;
    check("im_rda", {bus.rf_rd_en, bus.rf_rd_addr}, {1'b1, 3'd3});
    step();
    check("im_rdb", {bus.rf_rd_en, bus.op_valid}, 2'b00);
    step();
    check("im_valid", {bus.op_valid, bus.rf_rd_en}, 2'b10);
    step();
    check("im_done", bus.busy, 1'b0);
    // backpressure, then back-to-back issue from VALID
    bus.op_ready = 1'b0;
    issue(3'd2, 3'd5, 1'b0, 16'h0, {16'h1234, 16'h00FF});
    step();
    bus.start = 0;
    step(); step(); step();
    check("bp_valid", bus.op_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      bus.start = i[0]; bus.src_a = 3'd3; bus.src_b = 3'd3;
      step();
      check("bp_hold", {bus.op_valid, bus.rf_rd_en, bus.op_a, bus.op_b}, {1'b1, 1'b0, 16'h1234, 16'h00FF});
    end
    bus.op_ready = 1'b1;
    issue(3'd1, 3'd1, 1'b0, 16'h0, {16'h8001, 16'h8001});
    step();
    bus.start = 0;
    check("b2b_rda", {bus.rf_rd_en, bus.op_valid, bus.rf_rd_addr}, {1'b1, 1'b0, 3'd1});
    step(); step(); step();
    check("b2b_valid", bus.op_valid, 1'b1);
    step();
    // R0 reads as zero even with garbage on the read bus
    force_ff = 1'b1;
    issue(3'd0, 3'd4, 1'b1, 16'h1357, {16'h0000, 16'h1357});
    step();
    bus.start = 0;
    step(); step();
    check("r0_valid", bus.op_valid, 1'b1);
    step();
    force_ff = 1'b0;
    // flush during CAP_B
    bus.start = 1; bus.src_a = 3'd4; bus.src_b = 3'd6; bus.use_imm = 0;
    step();
    bus.start = 0;
    step(); step();
    check("fl_capb_a", {16'd0, bus.op_a}, 32'h4444);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("fl_idle", {bus.busy, bus.op_valid, bus.rf_rd_en}, 3'b000);
    check("fl_keep", {bus.op_a, bus.op_b}, {16'h4444, 16'h1357});
    for (int i = 0; i < 3; i++) begin
      step();
      check("fl_novalid", {bus.op_valid, bus.busy}, 2'b00);
    end
    // async reset while in RD_B
    bus.start = 1; bus.src_a = 3'd2; bus.src_b = 3'd5;
    step();
    bus.start = 0;
    step();
    check("ar_rdb", {bus.rf_rd_en, bus.rf_rd_addr}, {1'b1, 3'd5});
    #2 rst = 1'b1;
    #1 check("ar_zero", {bus.rf_rd_en, bus.op_valid, bus.busy, bus.rf_rd_addr, bus.op_a, bus.op_b}, 38'd0);
    #1 rst = 1'b0;
    step();
    issue(3'd3, 3'd1, 1'b0, 16'h0, {16'hAAAA, 16'h8001});
    step();
    bus.start = 0;
    step(); step(); step();
    check("ar_valid", bus.op_valid, 1'b1);
    step();
    check("sb_drain", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
